crc_lut_engine: RTL and testbench
=================================

# crc_lut_engine

Byte-serial CRC-32 engine that drives the 256-entry CRC lookup table and folds its output into a running CRC register, one byte per clock. Sits directly upstream of the table block (crctab_ev29 or any table with the same port shape): it produces the table address, consumes the table data combinationally, and delivers one CRC word per frame over a valid/ready result port. Frames are delimited by start- and end-of-frame flags on the byte stream.

## Interface
- INIT, 32'hFFFFFFFF, CRC register seed applied on the first byte of every frame
- XOROUT, 32'hFFFFFFFF, final XOR mask (used only when the macro in Configuration is defined)

- clk  in  1  clock, all logic rising-edge
- rstn  in  1  reset, synchronous, active-low
- in_valid  in  1  byte present
- in_ready  out  1  engine accepts byte this cycle
- in_data  in  8  payload byte
- in_sof  in  1  byte is first of frame
- in_eof  in  1  byte is last of frame (sof and eof may both be set)
- tab_addr  out  32  table address, {24'h0, index}
- tab_rdata  in  32  table entry, combinational from tab_addr
- crc_valid  out  1  result held
- crc_ready  in  1  consumer takes result
- crc_out  out  32  frame CRC
- crc_len  out  16  bytes in frame, saturating at 16'hFFFF
- err  out  1  one-cycle pulse: byte dropped (no sof while IDLE)

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- Handshake on each side: transfer when valid & ready. in_ready = (state != DONE).
- Effective previous CRC: INIT if in_sof, else crc_reg.
- index = prev[31:24] ^ in_data; tab_addr = {24'h0, index}; next = {prev[23:0], 8'h00} ^ tab_rdata.
- IDLE: accepted byte with in_sof -> crc_reg <= next, len <= 1, go RUN (or DONE if in_eof). Accepted byte without in_sof -> dropped, err pulses, stay IDLE.
- RUN: accepted byte -> crc_reg <= next, len <= len+1 (saturating). in_sof mid-frame restarts the frame from INIT, len <= 1, no err. in_eof -> go DONE.
- Entering DONE: crc_out <= next (^ XOROUT if enabled), crc_len <= final length, crc_valid <= 1.
- DONE: hold crc_out/crc_len stable while crc_valid & !crc_ready. On crc_ready -> crc_valid <= 0, go IDLE.
- tab_addr is driven from in_data every cycle regardless of in_valid; only accepted bytes update state.

## Timing
- Reset (rstn low at a clk edge): state IDLE, crc_reg 0, crc_out 0, crc_len 0, crc_valid 0, err 0. in_ready is 1 in the cycle after reset. Reset mid-frame or mid-DONE discards all state and any held result.
- Throughput: one byte per clock in IDLE/RUN.
- Latency: eof byte accepted at edge N -> crc_valid high after edge N, visible in cycle N+1.
- in_ready drops in the same cycle crc_valid rises. It rises again in the cycle after the result handshake. Minimum gap between frames: 1 cycle (result taken immediately).
- err: registered, high for exactly one cycle following the dropping edge.
- Length counter: 16 bits. Sticks at 16'hFFFF; the CRC still updates.

## Configuration
- CRC_LUT_ENGINE_XOROUT_EN defined: crc_out = final crc_reg ^ XOROUT.
- Not defined: crc_out = final crc_reg raw. The XOROUT parameter is ignored.

## Test plan
Bench ties tab_* to the ev29 table block with INIT = 32'hFFFFFFFF.
- Single byte 0x00 with sof+eof -> one cycle later crc_valid=1, crc_len=1, crc_out=32'h27974453 (XOROUT_EN) / 32'hD868BBAC (without); tab_addr=8'hFF during the byte.
- Frame 0xFF(sof), 0x00(eof) back-to-back -> crc_out=32'h2797BB53 / 32'hD86844AC, crc_len=2.
- Hold crc_ready=0 for 5 cycles after the result -> crc_out stable, in_ready=0, a presented byte is not accepted. crc_ready=1 -> in_ready=1 next cycle, and a new sof frame gives a correct result.
- Byte without sof in IDLE -> err pulses for 1 cycle; a following sof+eof 0x00 frame still yields 32'h27974453.
- Mid-frame sof: 0x12(sof), 0x34, then 0x00(sof+eof) -> result equals the single-byte 0x00 case, crc_len=1.
- rstn low for 1 cycle in RUN after 3 bytes -> all outputs 0. A subsequent 0xFF/0x00 frame matches the second scenario.

Source files
------------

// File: rtl/crc_lut_engine.sv
// Byte-serial CRC-32 engine: drives an external 256-entry lookup table and folds one byte per clock.
// Optional final XOR mask enabled by defining CRC_LUT_ENGINE_XOROUT_EN.
module crc_lut_engine #(
  parameter logic [31:0] INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [7:0]  i_in_data,
  input  logic        i_in_sof,
  input  logic        i_in_eof,
  output logic [31:0] o_tab_addr,
  input  logic [31:0] i_tab_rdata,
  output logic        o_crc_valid,
  input  logic        i_crc_ready,
  output logic [31:0] o_crc_out,
  output logic [15:0] o_crc_len,
  output logic        o_err
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

`ifdef CRC_LUT_ENGINE_XOROUT_EN
  localparam logic [31:0] FinalMask = XOROUT;
`else
  localparam logic [31:0] FinalMask = XOROUT & 32'h0;
`endif

  state_t      r_state;
  logic [31:0] r_crc;
  logic [15:0] r_len;
  logic [31:0] r_crc_out;
  logic [15:0] r_crc_len;
  logic        r_crc_valid;
  logic        r_err;

  logic [31:0] w_prev;
  logic [7:0]  w_index;
  logic [31:0] w_next;
  logic        w_accept;
  logic [15:0] w_len_next;

  // A start-of-frame byte always reseeds, so a mid-frame sof restarts cleanly.
  assign w_prev     = i_in_sof ? INIT : r_crc;
  assign w_index    = w_prev[31:24] ^ i_in_data;
  assign w_next     = {w_prev[23:0], 8'h00} ^ i_tab_rdata;
  assign o_tab_addr = {24'h0, w_index};

  assign o_in_ready = (r_state != StDone);
  assign w_accept   = i_in_valid & o_in_ready;

  always_comb begin
    w_len_next = r_len;
    if (i_in_sof) begin
      w_len_next = 16'd1;
    end else if (r_len != 16'hFFFF) begin
      w_len_next = r_len + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state     <= StIdle;
      r_crc       <= 32'h0;
      r_len       <= 16'h0;
      r_crc_out   <= 32'h0;
      r_crc_len   <= 16'h0;
      r_crc_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        StIdle, StRun: begin
          if (w_accept) begin
            if (r_state == StIdle && !i_in_sof) begin
              r_err <= 1'b1;
            end else begin
              r_crc <= w_next;
              r_len <= w_len_next;
              if (i_in_eof) begin
                r_crc_out   <= w_next ^ FinalMask;
                r_crc_len   <= w_len_next;
                r_crc_valid <= 1'b1;
                r_state     <= StDone;
              end else begin
                r_state <= StRun;
              end
            end
          end
        end
        StDone: begin
          if (i_crc_ready) begin
            r_crc_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_crc_out   = r_crc_out;
  assign o_crc_len   = r_crc_len;
  assign o_crc_valid = r_crc_valid;
  assign o_err       = r_err;

endmodule

// File: tb/tb_crc_lut_engine.sv
// Self-checking bench for crc_lut_engine: directed vector table, corner sequences and random frames
// checked against a frame-level CRC model. Honours CRC_LUT_ENGINE_XOROUT_EN like the design.
module tb_crc_lut_engine;

  localparam logic [31:0] Init = 32'hFFFFFFFF;
`ifdef CRC_LUT_ENGINE_XOROUT_EN
  localparam logic [31:0] Mask = 32'hFFFFFFFF;
`else
  localparam logic [31:0] Mask = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h0;
  logic        in_sof = 1'b0;
  logic        in_eof = 1'b0;
  logic [31:0] tab_addr;
  logic [31:0] tab_rdata;
  logic        crc_valid;
  logic        crc_ready = 1'b0;
  logic [31:0] crc_out;
  logic [15:0] crc_len;
  logic        err;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  // Stand-in lookup table: entries 0x00 and 0xFF match the ev29 table, the rest are arbitrary.
  function automatic logic [31:0] tab_fn(input logic [7:0] idx);
    if (idx == 8'h00) return 32'h0;
    if (idx == 8'hFF) return 32'h279744AC;
    return (32'(idx) * 32'h9E3779B1) ^ {idx, ~idx, idx, ~idx};
  endfunction

  assign tab_rdata = tab_fn(tab_addr[7:0]);

  crc_lut_engine #(.INIT(Init), .XOROUT(32'hFFFFFFFF)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .i_in_sof(in_sof), .i_in_eof(in_eof), .o_tab_addr(tab_addr),
    .i_tab_rdata(tab_rdata), .o_crc_valid(crc_valid), .i_crc_ready(crc_ready),
    .o_crc_out(crc_out), .o_crc_len(crc_len), .o_err(err)
  );

  function automatic logic [31:0] fold(input logic [31:0] crc, input logic [7:0] b);
    return {crc[23:0], 8'h00} ^ tab_fn(crc[31:24] ^ b);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic s, input logic e);
    in_valid = v; in_data = d; in_sof = s; in_eof = e;
  endtask

  task automatic expect_result(input string name, input logic [31:0] exp, input logic [15:0] len);
    check({name, ".valid"}, 32'(crc_valid), 32'd1);
    check({name, ".crc"}, crc_out, exp);
    check({name, ".len"}, 32'(crc_len), 32'(len));
    check({name, ".in_ready"}, 32'(in_ready), 32'd0);
  endtask

  task automatic take_result(input string name);
    crc_ready = 1'b1;
    tick();
    crc_ready = 1'b0;
    check({name, ".ready_after"}, 32'(in_ready), 32'd1);
    check({name, ".valid_after"}, 32'(crc_valid), 32'd0);
  endtask

  task automatic frame00(input string name);
    drive(1'b1, 8'h00, 1'b1, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    expect_result(name, 32'hD868BBAC ^ Mask, 16'd1);
    take_result(name);
  endtask

  task automatic frame_ff00(input string name);
    drive(1'b1, 8'hFF, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'h00, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    expect_result(name, 32'hD86844AC ^ Mask, 16'd2);
    take_result(name);
  endtask

  typedef struct {
    string       name;
    int          n;
    logic [7:0]  d [3];
    logic [2:0]  sof;
    logic [2:0]  eof;
    logic [31:0] raw;
    logic [15:0] len;
  } vec_t;

  vec_t vecs [3];

  initial begin
    logic [31:0] m_crc;
    logic [15:0] m_len;
    logic [31:0] held;

    vecs[0].name = "single00"; vecs[0].n = 1; vecs[0].d = '{8'h00, 8'h00, 8'h00};
    vecs[0].sof = 3'b001; vecs[0].eof = 3'b001; vecs[0].raw = 32'hD868BBAC; vecs[0].len = 16'd1;
    vecs[1].name = "ff00"; vecs[1].n = 2; vecs[1].d = '{8'hFF, 8'h00, 8'h00};
    vecs[1].sof = 3'b001; vecs[1].eof = 3'b010; vecs[1].raw = 32'hD86844AC; vecs[1].len = 16'd2;
    vecs[2].name = "midsof"; vecs[2].n = 3; vecs[2].d = '{8'h12, 8'h34, 8'h00};
    vecs[2].sof = 3'b101; vecs[2].eof = 3'b100; vecs[2].raw = 32'hD868BBAC; vecs[2].len = 16'd1;

    // Reset state
    tick(); tick();
    rstn = 1'b1;
    check("rst.valid", 32'(crc_valid), 32'd0);
    check("rst.crc", crc_out, 32'h0);
    check("rst.len", 32'(crc_len), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);

    // Directed vector table
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        drive(1'b1, vecs[i].d[j], vecs[i].sof[j], vecs[i].eof[j]);
        if (i == 0) begin
          #1 check("tab_addr", tab_addr, 32'h000000FF);
        end
        tick();
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      expect_result(vecs[i].name, vecs[i].raw ^ Mask, vecs[i].len);
      take_result(vecs[i].name);
    end

    // Result held under backpressure; a presented byte must not be taken
    drive(1'b1, 8'hFF, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'h00, 1'b0, 1'b1);
    tick();
    held = crc_out;
    check("hold.first", held, 32'hD86844AC ^ Mask);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 8'h55, 1'b1, 1'b1);
      tick();
      check("hold.crc", crc_out, held);
      check("hold.len", 32'(crc_len), 32'd2);
      check("hold.in_ready", 32'(in_ready), 32'd0);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    take_result("hold");
    frame00("after_hold");

    // Byte without sof while idle is dropped with a one-cycle err pulse
    drive(1'b1, 8'hAB, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("drop.err", 32'(err), 32'd1);
    tick();
    check("drop.err_clear", 32'(err), 32'd0);
    frame00("after_drop");

    // Reset in the middle of a frame
    drive(1'b1, 8'hFF, 1'b1, 1'b0); tick();
    drive(1'b1, 8'h11, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h22, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("midrst.valid", 32'(crc_valid), 32'd0);
    check("midrst.crc", crc_out, 32'h0);
    check("midrst.len", 32'(crc_len), 32'd0);
    check("midrst.err", 32'(err), 32'd0);
    check("midrst.in_ready", 32'(in_ready), 32'd1);
    frame_ff00("after_rst");

    // Random frames with idle gaps, stray bytes and occasional mid-frame restarts
    for (int f = 0; f < 40; f++) begin
      int n;
      if ($urandom_range(0, 7) == 0) begin
        drive(1'b1, 8'($urandom), 1'b0, 1'($urandom));
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("rand.err", 32'(err), 32'd1);
      end
      n = $urandom_range(1, 24);
      m_crc = Init;
      m_len = 16'd0;
      for (int j = 0; j < n; j++) begin
        logic [7:0] b;
        logic       s;
        int         gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          drive(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
          tick();
        end
        b = 8'($urandom);
        s = (j == 0) || ($urandom_range(0, 15) == 0);
        if (s) begin
          m_crc = Init;
          m_len = 16'd0;
        end
        m_crc = fold(m_crc, b);
        m_len = m_len + 16'd1;
        drive(1'b1, b, s, j == n - 1);
        tick();
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      expect_result("rand", m_crc ^ Mask, m_len);
      take_result("rand");
    end

    // Length saturation: 65537 bytes, counter sticks at 16'hFFFF while the CRC keeps folding
    m_crc = Init;
    m_len = 16'd0;
    for (int j = 0; j < 65537; j++) begin
      logic [7:0] b;
      b = 8'($urandom);
      m_crc = fold(m_crc, b);
      if (m_len != 16'hFFFF) m_len = m_len + 16'd1;
      drive(1'b1, b, j == 0, j == 65536);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    expect_result("sat", m_crc ^ Mask, m_len);
    check("sat.len_ffff", 32'(crc_len), 32'h0000FFFF);
    take_result("sat");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
